fetch_unit_r32i: RTL and testbench

- Instruction fetch front end that consumes ProgAddr from the RV32I program counter and returns fetched instructions to decode.
- Samples the PC address, issues a req/ack read to instruction memory, and holds the returned word in an output register with a valid/ready handshake.
- Drives PCStall back to the PC while a fetch is outstanding.
- Discards in-flight fetches when a taken branch redirects the PC.

---
 rtl/fetch_unit_r32i.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit_r32i.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_r32i.sv
// Fetch front end: one req/ack read per accepted PC, 2-edge latency at single-cycle ack, word held on valid/ready.
// PCStall holds the PC while a read or a stalled decode is pending; FETCH_TIMEOUT_EN adds an ack-wait limit.
module fetch_unit_r32i #(
   parameter int               dataW     = 32,
   parameter logic [dataW-1:0] NOP_INSTR = dataW'(32'h00000013),
   parameter int               TIMEOUT   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [dataW-1:0] ProgAddr,
   input  logic             Flush,
   output logic             PCStall,
   output logic             MemReq,
   output logic [dataW-1:0] MemAddr,
   input  logic             MemAck,
   input  logic [dataW-1:0] MemRData,
   output logic [dataW-1:0] Instr,
   output logic [dataW-1:0] InstrAddr,
   output logic             InstrValid,
   input  logic             InstrReady,
   output logic             FetchFault,
   output logic             TimeoutErr
);

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HOLD} fetchStateT;

   fetchStateT       state, stateNxt;
   logic             accept;
   logic             memReqNxt, instrValidNxt, fetchFaultNxt;
   logic [dataW-1:0] memAddrNxt, instrNxt, instrAddrNxt;

`ifdef FETCH_TIMEOUT_EN
   localparam int CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CntW-1:0] waitCnt, waitCntNxt;
   logic            timeoutErrNxt, timeoutHit;

   assign timeoutHit = (waitCnt == CntW'(TIMEOUT - 1));
`else
   logic unusedTimeout;
   assign unusedTimeout = (TIMEOUT != 0);
   assign TimeoutErr    = 1'b0;
`endif

   // A redirect in HOLD wins over the handshake, so no address is taken that cycle.
   assign accept  = reset && ((state == IDLE) || ((state == HOLD) && InstrReady && !Flush));
   assign PCStall = !accept;

   always_comb begin
      stateNxt      = state;
      memReqNxt     = MemReq;
      memAddrNxt    = MemAddr;
      instrNxt      = Instr;
      instrAddrNxt  = InstrAddr;
      instrValidNxt = InstrValid;
      fetchFaultNxt = FetchFault;
`ifdef FETCH_TIMEOUT_EN
      timeoutErrNxt = TimeoutErr;
      waitCntNxt    = waitCnt;
`endif
      case (state)
         WAIT: begin
            if (MemAck) begin
               memReqNxt = 1'b0;
               if (Flush) begin
                  stateNxt = IDLE;
               end else begin
                  instrNxt      = MemRData;
                  instrValidNxt = 1'b1;
                  fetchFaultNxt = 1'b0;
                  stateNxt      = HOLD;
               end
            end else if (Flush) begin
               stateNxt = DRAIN;
`ifdef FETCH_TIMEOUT_EN
               waitCntNxt = '0;
`endif
            end
`ifdef FETCH_TIMEOUT_EN
            else if (timeoutHit) begin
               memReqNxt     = 1'b0;
               instrNxt      = NOP_INSTR;
               instrValidNxt = 1'b1;
               fetchFaultNxt = 1'b1;
               timeoutErrNxt = 1'b1;
               stateNxt      = HOLD;
            end else begin
               waitCntNxt = waitCnt + 1'b1;
            end
`endif
         end
         // The bus cannot withdraw a request, so a killed read still waits for its ack.
         DRAIN: begin
            if (MemAck) begin
               memReqNxt = 1'b0;
               stateNxt  = IDLE;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (timeoutHit) begin
               memReqNxt = 1'b0;
               stateNxt  = IDLE;
            end else begin
               waitCntNxt = waitCnt + 1'b1;
            end
`endif
         end
         HOLD: begin
            if (Flush) begin
               instrValidNxt = 1'b0;
               fetchFaultNxt = 1'b0;
`ifdef FETCH_TIMEOUT_EN
               timeoutErrNxt = 1'b0;
`endif
               stateNxt      = IDLE;
            end
         end
         default: stateNxt = IDLE;
      endcase

      if (accept) begin
         instrAddrNxt = ProgAddr;
`ifdef FETCH_TIMEOUT_EN
         timeoutErrNxt = 1'b0;
`endif
         if (ProgAddr[1:0] == 2'b00) begin
            memReqNxt     = 1'b1;
            memAddrNxt    = ProgAddr;
            instrValidNxt = 1'b0;
            fetchFaultNxt = 1'b0;
            stateNxt      = WAIT;
`ifdef FETCH_TIMEOUT_EN
            waitCntNxt = '0;
`endif
         end else begin
            instrNxt      = NOP_INSTR;
            instrValidNxt = 1'b1;
            fetchFaultNxt = 1'b1;
            stateNxt      = HOLD;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         MemReq     <= 1'b0;
         MemAddr    <= '0;
         Instr      <= '0;
         InstrAddr  <= '0;
         InstrValid <= 1'b0;
         FetchFault <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         TimeoutErr <= 1'b0;
         waitCnt    <= '0;
`endif
      end else begin
         state      <= stateNxt;
         MemReq     <= memReqNxt;
         MemAddr    <= memAddrNxt;
         Instr      <= instrNxt;
         InstrAddr  <= instrAddrNxt;
         InstrValid <= instrValidNxt;
         FetchFault <= fetchFaultNxt;
`ifdef FETCH_TIMEOUT_EN
         TimeoutErr <= timeoutErrNxt;
         waitCnt    <= waitCntNxt;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_unit_r32i.sv
// Bench for fetch_unit_r32i: vector table, directed corner sequences, then randomized traffic vs a transaction model.
module tb_fetch_unit_r32i;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] ProgAddr, MemAddr, MemRData, Instr, InstrAddr;
   logic        Flush, PCStall, MemReq, MemAck, InstrValid, InstrReady, FetchFault, TimeoutErr;

   int checks = 0;
   int errors = 0;

   fetch_unit_r32i #(.dataW(32), .NOP_INSTR(32'h00000013), .TIMEOUT(16)) dut (
      .clock(clock), .reset(reset), .ProgAddr(ProgAddr), .Flush(Flush), .PCStall(PCStall),
      .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemRData(MemRData),
      .Instr(Instr), .InstrAddr(InstrAddr), .InstrValid(InstrValid), .InstrReady(InstrReady),
      .FetchFault(FetchFault), .TimeoutErr(TimeoutErr)
   );

   always #5 clock = ~clock;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h00500093;
   endfunction

   function automatic logic [31:0] redirect();
      logic [31:0] a;
      a = $urandom & 32'h00000FFC;
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      return a;
   endfunction

   typedef struct {
      logic [31:0] addr;
      int          dly;
      logic [31:0] rdata;
      int          rdyDly;
      logic [31:0] expInstr;
      logic        expFault;
      int          expLat;
      int          expReq;
   } vec_t;

   vec_t vecs[7];

   // Entered at a drive point with the DUT idle; leaves it idle again via a flush in HOLD.
   task automatic runVec(input vec_t v);
      int   lat;
      int   reqCyc;
      logic got;
      lat = -1; reqCyc = 0; got = 1'b0;
      ProgAddr = v.addr; InstrReady = 1'b0; Flush = 1'b0; MemAck = 1'b0; MemRData = 32'h0;
      @(negedge clock);
      chk1("vec idle accept", PCStall, 1'b0);
      chk1("vec idle valid", InstrValid, 1'b0);
      chk1("vec idle fault", FetchFault, 1'b0);
      chk1("vec idle req", MemReq, 1'b0);
      tick();
      for (int c = 0; c < 40; c++) begin
         MemAck   = (c == v.dly);
         MemRData = MemAck ? v.rdata : (32'hBAD00000 | 32'(c));
         @(negedge clock);
         if (InstrValid) begin
            got = 1'b1;
            lat = c;
            break;
         end
         if (MemReq) begin
            reqCyc++;
            chk32("vec MemAddr stable", MemAddr, v.addr);
         end
         chk1("vec stall while waiting", PCStall, 1'b1);
         tick();
      end
      chk1("vec returned", got, 1'b1);
      chk32("vec latency", 32'(lat), 32'(v.expLat));
      chk32("vec req cycles", 32'(reqCyc), 32'(v.expReq));
      chk32("vec Instr", Instr, v.expInstr);
      chk32("vec InstrAddr", InstrAddr, v.addr);
      chk1("vec FetchFault", FetchFault, v.expFault);
      tick();
      for (int h = 0; h < v.rdyDly; h++) begin
         MemAck = 1'b1; MemRData = 32'h12345678;
         @(negedge clock);
         chk1("hold valid", InstrValid, 1'b1);
         chk32("hold Instr", Instr, v.expInstr);
         chk32("hold InstrAddr", InstrAddr, v.addr);
         chk1("hold fault", FetchFault, v.expFault);
         chk1("hold stall", PCStall, 1'b1);
         chk1("hold no req", MemReq, 1'b0);
         tick();
      end
      MemAck = 1'b0; Flush = 1'b1; InstrReady = 1'b1;
      @(negedge clock);
      chk1("hold flush stall", PCStall, 1'b1);
      tick();
      Flush = 1'b0; InstrReady = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      logic        acc, busyV, liveV, presV, tFault;
      logic [31:0] tAddr, tInstr, reqAddr, pc;
      int          cyc, dly;

      vecs[0] = '{32'h00000000, 0, 32'h00500093, 1, 32'h00500093, 1'b0, 1, 1};
      vecs[1] = '{32'h00000028, 5, 32'h00A00113, 3, 32'h00A00113, 1'b0, 6, 6};
      vecs[2] = '{32'h00000006, 0, 32'hFFFFFFFF, 3, 32'h00000013, 1'b1, 0, 0};
      vecs[3] = '{32'h00000001, 2, 32'h11111111, 1, 32'h00000013, 1'b1, 0, 0};
      vecs[4] = '{32'hFFFFFFFC, 2, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 3, 3};
      vecs[5] = '{32'h00001003, 0, 32'h00000000, 2, 32'h00000013, 1'b1, 0, 0};
      vecs[6] = '{32'h00000100, 1, 32'h00000013, 1, 32'h00000013, 1'b0, 2, 2};

      reset = 1'b0; ProgAddr = 32'h0; Flush = 1'b0; MemAck = 1'b0; MemRData = 32'h0; InstrReady = 1'b0;
      repeat (3) @(negedge clock);
      chk1("reset PCStall", PCStall, 1'b1);
      chk1("reset MemReq", MemReq, 1'b0);
      chk32("reset MemAddr", MemAddr, 32'h0);
      chk32("reset Instr", Instr, 32'h0);
      chk32("reset InstrAddr", InstrAddr, 32'h0);
      chk1("reset InstrValid", InstrValid, 1'b0);
      chk1("reset FetchFault", FetchFault, 1'b0);
      chk1("reset TimeoutErr", TimeoutErr, 1'b0);
      tick();
      reset = 1'b1;

      // back-to-back fetch with single-cycle ack, then flush racing an ack
      ProgAddr = 32'h0; InstrReady = 1'b1;
      @(negedge clock); chk1("b2b accept0", PCStall, 1'b0); chk1("b2b noreq", MemReq, 1'b0);
      tick();
      MemAck = 1'b1; MemRData = 32'h00500093; ProgAddr = 32'h4;
      @(negedge clock);
      chk1("b2b req", MemReq, 1'b1); chk32("b2b addr", MemAddr, 32'h0);
      chk1("b2b stall", PCStall, 1'b1); chk1("b2b notvalid", InstrValid, 1'b0);
      tick();
      MemAck = 1'b0; MemRData = 32'h0;
      @(negedge clock);
      chk1("b2b valid", InstrValid, 1'b1); chk32("b2b Instr", Instr, 32'h00500093);
      chk32("b2b InstrAddr", InstrAddr, 32'h0); chk1("b2b fault", FetchFault, 1'b0);
      chk1("b2b accept1", PCStall, 1'b0);
      tick();
      MemAck = 1'b1; Flush = 1'b1; MemRData = 32'hBADBAD00; ProgAddr = 32'h10;
      @(negedge clock);
      chk1("b2b valid drop", InstrValid, 1'b0); chk1("b2b req2", MemReq, 1'b1);
      chk32("b2b addr2", MemAddr, 32'h4); chk32("b2b InstrAddr2", InstrAddr, 32'h4);
      chk1("b2b stall2", PCStall, 1'b1);
      tick();

      // flush two cycles into WAIT, drain, then fetch the redirect target
      MemAck = 1'b0; Flush = 1'b0;
      @(negedge clock);
      chk1("ackflush noreq", MemReq, 1'b0); chk1("ackflush novalid", InstrValid, 1'b0);
      chk1("ackflush idle", PCStall, 1'b0);
      tick();
      @(negedge clock); chk1("drain wait req", MemReq, 1'b1); chk32("drain wait addr", MemAddr, 32'h10);
      tick();
      Flush = 1'b1; ProgAddr = 32'h38;
      @(negedge clock); chk1("drain flush stall", PCStall, 1'b1);
      tick();
      @(negedge clock);
      chk1("drain req held", MemReq, 1'b1); chk32("drain addr held", MemAddr, 32'h10);
      chk1("drain novalid", InstrValid, 1'b0); chk1("drain stall", PCStall, 1'b1);
      tick();
      Flush = 1'b0; MemAck = 1'b1; MemRData = 32'hCAFEF00D;
      @(negedge clock); chk1("drain ack req", MemReq, 1'b1); chk1("drain ack stall", PCStall, 1'b1);
      tick();
      MemAck = 1'b0;
      @(negedge clock);
      chk1("drain discard", InstrValid, 1'b0); chk1("drain done noreq", MemReq, 1'b0);
      chk1("drain done idle", PCStall, 1'b0);
      tick();
      MemAck = 1'b1; MemRData = 32'h00C00193;
      @(negedge clock); chk1("redir req", MemReq, 1'b1); chk32("redir addr", MemAddr, 32'h38);
      tick();
      MemAck = 1'b0; InstrReady = 1'b0;
      @(negedge clock);
      chk1("redir valid", InstrValid, 1'b1); chk32("redir Instr", Instr, 32'h00C00193);
      chk32("redir InstrAddr", InstrAddr, 32'h38); chk1("redir stall", PCStall, 1'b1);
      tick();

      // asynchronous reset in the middle of WAIT
      InstrReady = 1'b1; ProgAddr = 32'h40;
      @(negedge clock); chk1("arst accept", PCStall, 1'b0);
      tick();
      @(negedge clock); chk1("arst wait req", MemReq, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk1("arst MemReq", MemReq, 1'b0); chk1("arst InstrValid", InstrValid, 1'b0);
      chk1("arst PCStall", PCStall, 1'b1); chk32("arst MemAddr", MemAddr, 32'h0);
      chk32("arst InstrAddr", InstrAddr, 32'h0);
      tick();
      reset = 1'b1; InstrReady = 1'b0;

      for (int i = 0; i < 7; i++) runVec(vecs[i]);

`ifdef FETCH_TIMEOUT_EN
      ProgAddr = 32'h80; MemAck = 1'b0; Flush = 1'b0; InstrReady = 1'b0;
      @(negedge clock); chk1("tmo accept", PCStall, 1'b0);
      tick();
      for (int i = 0; i < 16; i++) begin
         @(negedge clock); chk1("tmo req held", MemReq, 1'b1);
         tick();
      end
      @(negedge clock);
      chk1("tmo req drop", MemReq, 1'b0); chk1("tmo valid", InstrValid, 1'b1);
      chk32("tmo Instr", Instr, NOP); chk1("tmo fault", FetchFault, 1'b1);
      chk1("tmo err", TimeoutErr, 1'b1); chk32("tmo InstrAddr", InstrAddr, 32'h80);
      tick();
      Flush = 1'b1;
      @(negedge clock);
      tick();
      Flush = 1'b0;
`endif

      // randomized traffic against a transaction-level model
      busyV = 1'b0; liveV = 1'b0; presV = 1'b0; tFault = 1'b0;
      tAddr = 32'h0; tInstr = 32'h0; reqAddr = 32'h0; pc = 32'h200; cyc = 0; dly = 0;
      for (int n = 0; n < 1500; n++) begin
         Flush = ($urandom_range(0, 11) == 0);
         if (Flush) pc = redirect();
         ProgAddr   = pc;
         InstrReady = ($urandom_range(0, 9) < 7);
         if (busyV) begin
            cyc++;
            MemAck = (cyc == dly + 1);
         end else begin
            MemAck = ($urandom_range(0, 7) == 0);
         end
         MemRData = (busyV && MemAck) ? memWord(reqAddr) : $urandom;
         acc = !busyV && (!liveV || (presV && InstrReady && !Flush));
         @(negedge clock);
         chk1("rnd PCStall", PCStall, !acc);
         chk1("rnd MemReq", MemReq, busyV);
         if (busyV) chk32("rnd MemAddr", MemAddr, reqAddr);
         chk1("rnd InstrValid", InstrValid, presV);
         chk1("rnd FetchFault", FetchFault, presV && tFault);
         if (presV) begin
            chk32("rnd Instr", Instr, tInstr);
            chk32("rnd InstrAddr", InstrAddr, tAddr);
         end
         chk1("rnd TimeoutErr", TimeoutErr, 1'b0);
         if (liveV && presV && InstrReady && !Flush) begin
            liveV = 1'b0; presV = 1'b0;
         end else if (Flush && liveV) begin
            liveV = 1'b0; presV = 1'b0;
         end
         if (busyV && MemAck) begin
            busyV = 1'b0;
            if (liveV) presV = 1'b1;
         end
         if (acc) begin
            liveV = 1'b1;
            tAddr = ProgAddr;
            if (ProgAddr[1:0] == 2'b00) begin
               busyV = 1'b1; presV = 1'b0; tFault = 1'b0;
               tInstr = memWord(ProgAddr); reqAddr = ProgAddr;
               cyc = 0; dly = $urandom_range(0, 6);
            end else begin
               presV = 1'b1; tFault = 1'b1; tInstr = NOP;
            end
            pc = ($urandom_range(0, 9) == 0) ? redirect() : pc + 32'd4;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
